// File: rtl/serial_out_arbiter_if.sv
// Request/serial-buffer bundle for serial_out_arbiter.
// master = requester side, slave = arbiter side.
interface serial_out_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic                      buf_go;
  logic [ADDR_W-1:0]         buf_addr;
  logic [DATA_W-1:0]         buf_data;

  modport master (
    output req, req_addr, req_data,
    input  ack, busy, buf_go,
    input  buf_addr, buf_data
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, busy, buf_go,
    output buf_addr, buf_data
  );
endinterface

// File: rtl/serial_out_arbiter.sv
// Round-robin arbiter sharing one serial out buffer.
// Frame end is timed by a counter; the buffer has no busy.
module serial_out_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 30,
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8
) (
  input logic                 clk_in,
  input logic                 reset,
  serial_out_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FRAME_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(FRAME_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST =
    IDX_W'(NUM_REQ - 1);

  generate
    if (FRAME_CYCLES < 2) begin : g_bad_frame
      $error("FRAME_CYCLES must be >= 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_nreq
      $error("NUM_REQ must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;

  logic                w_hit;
  logic [IDX_W-1:0]    w_pick;
  logic                w_go;
  logic                w_busy;
  logic [NUM_REQ-1:0]  w_ack;

  logic [ADDR_W-1:0]   w_addr_a [NUM_REQ];
  logic [DATA_W-1:0]   w_data_a [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr_a[g] =
        bus.req_addr[g*ADDR_W +: ADDR_W];
      assign w_data_a[g] =
        bus.req_data[g*DATA_W +: DATA_W];
    end
  endgenerate

  // Search last+1, last+2, ... modulo NUM_REQ.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [NUM_REQ-1:0] rq,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W:0]   s;
    logic             hit;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      s = {1'b0, last} + (IDX_W+1)'(i);
      if (s >= (IDX_W+1)'(NUM_REQ))
        s = s - (IDX_W+1)'(NUM_REQ);
      if (!hit && rq[s[IDX_W-1:0]]) begin
        hit = 1'b1;
        idx = s[IDX_W-1:0];
      end
    end
    return {hit, idx};
  endfunction

  always_comb begin
    {w_hit, w_pick} = rr_pick(bus.req, r_last);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    w_busy = 1'b1;
    w_ack  = '0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_hit)
          w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_go   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_ack[r_grant] = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counter already reads FRAME_CYCLES-1 during LAUNCH.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_last  <= LAST_RST;
      r_grant <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_grant <= w_pick;
            r_addr  <= w_addr_a[w_pick];
            r_data  <= w_data_a[w_pick];
            r_cnt   <= CNT_LOAD;
          end
        end
        S_LAUNCH, S_WAIT: begin
          if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          r_last <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack      = w_ack;
  assign bus.busy     = w_busy;
  assign bus.buf_go   = w_go;
  assign bus.buf_addr = r_addr;
  assign bus.buf_data = r_data;

endmodule

// File: tb/tb_serial_out_arbiter.sv
// Directed bench for serial_out_arbiter.
// Expected values are hand-computed per scenario.
module tb_serial_out_arbiter;
  localparam int NR = 4;
  localparam int FC = 30;
  localparam int AW = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   viol  = 0;

  always #5 clk = ~clk;

  serial_out_arbiter_if #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)
  ) bus ();

  serial_out_arbiter #(
    .NUM_REQ(NR), .FRAME_CYCLES(FC),
    .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk_in(clk),
    .reset (rst),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack != 0 && bus.buf_go) viol++;
      if ((bus.ack & (bus.ack - 1'b1)) != 0) viol++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_addr[k*AW +: AW] = a;
    bus.req_data[k*DW +: DW] = d;
  endtask

  task automatic wait_go(input string tag,
                         output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.buf_go && n < 200);
    if (!bus.buf_go) chk(tag, 32'(bus.buf_go), 1);
  endtask

  task automatic wait_ack(input string tag,
                          output logic [NR-1:0] a,
                          output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack == 0 && n < 200);
    a = bus.ack;
    if (bus.ack == 0) chk(tag, 32'(bus.ack), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] a;
    int n;
    int bad;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_go",   32'(bus.buf_go), 0);
    chk("rst_ack",  32'(bus.ack), 0);
    chk("rst_addr", 32'(bus.buf_addr), 0);
    chk("rst_data", 32'(bus.buf_data), 0);

    // single request
    rst = 1'b0;
    set_req(0, 7'h7F, 8'hFF);
    bus.req = 4'b0001;
    tick();
    chk("t1_go",   32'(bus.buf_go), 1);
    chk("t1_addr", 32'(bus.buf_addr), 32'h7F);
    chk("t1_data", 32'(bus.buf_data), 32'hFF);
    chk("t1_busy", 32'(bus.busy), 1);
    bad = 0;
    for (int c = 2; c <= 30; c++) begin
      tick();
      if (bus.buf_go || bus.ack != 0 || !bus.busy)
        bad++;
    end
    chk("t1_wait", 32'(bad), 0);
    tick();
    chk("t1_ack",   32'(bus.ack), 32'b0001);
    chk("t1_busyd", 32'(bus.busy), 1);
    bus.req = '0;
    tick();
    chk("t1_idle", 32'(bus.busy), 0);
    chk("t1_ack0", 32'(bus.ack), 0);

    // simultaneous 0 and 2
    do_reset();
    set_req(0, 7'h41, 8'hA0);
    set_req(2, 7'h12, 8'hB2);
    bus.req = 4'b0101;
    wait_go("t2_go1_tmo", n);
    chk("t2_lat1",  32'(n), 1);
    chk("t2_addr1", 32'(bus.buf_addr), 32'h41);
    wait_ack("t2_ack1_tmo", a, n);
    chk("t2_ack1", 32'(a), 32'b0001);
    chk("t2_len1", 32'(n), 30);
    bus.req[0] = 1'b0;
    wait_go("t2_go2_tmo", n);
    chk("t2_gap",   32'(n + 30), 32);
    chk("t2_addr2", 32'(bus.buf_addr), 32'h12);
    chk("t2_data2", 32'(bus.buf_data), 32'hB2);
    wait_ack("t2_ack2_tmo", a, n);
    chk("t2_ack2", 32'(a), 32'b0100);
    bus.req = '0;

    // fairness with all four requesting
    do_reset();
    for (int k = 0; k < NR; k++)
      set_req(k, AW'(8'h10 + k), DW'(8'hC0 + k));
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_ack("fair_tmo", a, n);
      chk("fair_ack",  32'(a), 32'(1 << (i % 4)));
      chk("fair_addr", 32'(bus.buf_addr),
          32'(8'h10 + (i % 4)));
      if (i == 7) bus.req = '0;
    end

    // stability: source data changes during WAIT
    set_req(1, 7'h33, 8'h5A);
    bus.req = 4'b0010;
    wait_go("t4_go_tmo", n);
    chk("t4_data", 32'(bus.buf_data), 32'h5A);
    tick();
    set_req(1, 7'h00, 8'h00);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.buf_go || bus.buf_data != 8'h5A ||
          bus.buf_addr != 7'h33)
        bad++;
    end
    chk("t4_hold", 32'(bad), 0);
    wait_ack("t4_ack_tmo", a, n);
    chk("t4_ack", 32'(a), 32'b0010);
    bus.req = '0;
    tick();
    tick();
    chk("t4_keep", 32'(bus.buf_data), 32'h5A);

    // reset in the middle of WAIT
    set_req(2, 7'h22, 8'h99);
    set_req(3, 7'h6C, 8'hC3);
    bus.req = 4'b0100;
    wait_go("t5_go_tmo", n);
    chk("t5_addr", 32'(bus.buf_addr), 32'h22);
    for (int c = 0; c < 15; c++) tick();
    rst = 1'b1;
    bus.req = 4'b1000;
    tick();
    chk("t5_ack",  32'(bus.ack), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_go",   32'(bus.buf_go), 0);
    chk("t5_addr0", 32'(bus.buf_addr), 0);
    chk("t5_data0", 32'(bus.buf_data), 0);
    rst = 1'b0;
    wait_go("t5_go2_tmo", n);
    chk("t5_lat",   32'(n), 1);
    chk("t5_addr3", 32'(bus.buf_addr), 32'h6C);
    wait_ack("t5_ack_tmo", a, n);
    chk("t5_ack3", 32'(a), 32'b1000);
    bus.req = '0;

    // requester drops req during WAIT
    set_req(1, 7'h05, 8'h50);
    bus.req = 4'b0010;
    wait_go("t6_go_tmo", n);
    for (int c = 0; c < 5; c++) tick();
    bus.req = '0;
    wait_ack("t6_ack_tmo", a, n);
    chk("t6_ack", 32'(a), 32'b0010);
    chk("t6_len", 32'(n + 5), 30);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.busy || bus.buf_go || bus.ack != 0)
        bad++;
    end
    chk("t6_idle", 32'(bad), 0);

    chk("excl", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
